bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-in, serial-out stage that feeds the `1011` sequence detector's serial input. It accepts WIDTH-bit words over a valid/ready handshake and shifts each word out MSB-first, one bit per clock. The serial output drives the detector's `xin` directly. Outside a word, the output holds a fixed idle level, and a bit-valid flag frames the active bits.

## Interface
- `WIDTH`, default 8: word width in bits; legal range is 2 to 32.
- `IDLE_BIT`, default 1'b0: level driven on `xout` whenever no word bit is being shifted.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `din`  input  WIDTH  parallel word to serialize.
- `din_valid`  input  1  upstream has a word on `din`.
- `din_ready`  output  1  block can accept a word this cycle; combinational.
- `xout`  output  1  serial bit to the detector `xin`; registered.
- `xout_valid`  output  1  `xout` carries a word bit this cycle; registered.
- `xout_last`  output  1  `xout` carries the LSB, the final bit of a word; registered.
- `busy`  output  1  shift register holds undelivered bits.

## Operation
- Handshake: a word is accepted at a rising edge where `din_valid && din_ready`.
  - `din` is sampled only at that edge.
  - Upstream must hold `din` and `din_valid` until accepted.
  - `din_valid` with `din_ready`=0 has no effect.
- State machine has two states.
  - **IDLE:** `xout`=IDLE_BIT, `xout_valid`=0, `busy`=0. On accept, load the shift register, clear `bit_cnt` to 0 and go to SHIFT.
  - **SHIFT:** each cycle presents `shreg[WIDTH-1]` and shifts left by one, filling the low bit with 0. `bit_cnt` increments.
  - At `bit_cnt`==WIDTH-1 the LSB is presented with `xout_last`=1. Next state is IDLE, or SHIFT if a next word is available (see Configuration).
- `bit_cnt` width: $clog2(WIDTH). It is never compared beyond WIDTH-1 and never wraps mid-word.
- `busy` = (state==SHIFT).
- Reset values:
  - state=IDLE, `shreg`=0, `bit_cnt`=0.
  - `xout`=IDLE_BIT, `xout_valid`=0, `xout_last`=0, `busy`=0.
  - `din_ready` is forced 0 while `rst`=1.
- Reset mid-word: the word is discarded and no further bits of it appear. `xout` returns to IDLE_BIT on the cycle after the reset edge. A buffered word, if any, is discarded too.

## Timing
- Latency: the word accepted at edge N drives its MSB on `xout` (`xout_valid`=1) from edge N+1. Its LSB appears at edge N+WIDTH.
- Each word occupies exactly WIDTH consecutive valid cycles; there are no gaps inside a word.
- `din_ready` is combinational from registered state only. It has no combinational path from `din_valid`.
- `xout`, `xout_valid` and `xout_last` change only on rising edges.

## Configuration
- Macro: `SER_HOLD_BUF_EN`.
- **Undefined:**
  - `din_ready` = (state==IDLE) && !rst.
  - After each word's LSB the block returns to IDLE for at least one cycle. This inserts ≥1 IDLE_BIT gap cycle between words, with `xout_valid`=0.
  - Throughput is at most WIDTH bits per WIDTH+1 cycles.
- **Defined:**
  - Adds a one-word holding register `hold`/`hold_full`. `din_ready` = !hold_full && !rst.
  - Accept while IDLE with hold empty: load `shreg` directly.
  - Accept in any other case: write `hold`.
  - At the LSB cycle, if `hold_full`: load `shreg` from `hold`, clear `hold_full` and stay in SHIFT. The next MSB follows the LSB on the very next edge, giving a gapless stream.
  - Accept on the same edge that `hold` drains: the new word goes into `hold`, and `hold_full` stays 1.
  - Reset clears `hold_full`.

## Test plan
- **Single word, WIDTH=4, IDLE_BIT=0:** accept `din`=4'b1011 at edge 1.
  - `xout` = 1,0,1,1 at edges 2–5, `xout_valid`=1, `xout_last`=1 only at edge 5.
  - Edge 6: `xout`=0, `xout_valid`=0.
  - A connected detector asserts `zout` in the cycle the final 1 is presented.
- **Back-to-back, WIDTH=4:** `din_valid` held with 4'b1011 then 4'b0110.
  - Without the macro: bits 1011, one idle 0, then 0110; `din_ready`=0 during edges 2–5.
  - With `SER_HOLD_BUF_EN`: 10110110 on consecutive edges, with `xout_valid` continuously 1.
- **Backpressure, WIDTH=8:** second word 8'hA5 presented while busy.
  - `din_ready` stays 0 (or 0 once `hold` is full) and `din` is not consumed.
  - 8'hA5 appears later intact, MSB-first: 1,0,1,0,0,1,0,1.
- **Reset mid-word, WIDTH=8:** accept 8'hFF, assert `rst` at the 3rd valid bit.
  - Next edge: `xout`=IDLE_BIT, `xout_valid`=0, `busy`=0.
  - No remaining 1s appear, and `din_ready` is 1 on the first cycle after `rst` deasserts.
- **IDLE_BIT=1, WIDTH=2:** idle `xout`=1 out of reset; accept 2'b00 → `xout` = 0,0 then back to 1.
- **Reset during accept:** `din_valid`=1 and `rst`=1 on the same edge. No word is accepted and `xout_valid` stays 0.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-in, MSB-first serial-out stage feeding the 1011 detector's xin.
// Optional one-word holding register for gapless streams: define SER_HOLD_BUF_EN.
module bit_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             xout,
  output logic             xout_valid,
  output logic             xout_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [CW-1:0]    bit_cnt, bit_cnt_nx;
  logic             xout_nx, xout_valid_nx, xout_last_nx;
  logic             accept;

`ifdef SER_HOLD_BUF_EN
  logic [WIDTH-1:0] hold, hold_nx;
  logic             hold_full, hold_full_nx;

  assign din_ready = !hold_full && !rst;
`else
  assign din_ready = (state == IDLE) && !rst;
`endif

  assign accept = din_valid && din_ready;
  assign busy   = (state == SHIFT);

  always_comb begin
    state_nx      = state;
    shreg_nx      = shreg;
    bit_cnt_nx    = bit_cnt;
    xout_nx       = IDLE_BIT;
    xout_valid_nx = 1'b0;
    xout_last_nx  = 1'b0;
`ifdef SER_HOLD_BUF_EN
    hold_nx       = hold;
    hold_full_nx  = hold_full;
`endif
    case (state)
      IDLE: begin
`ifdef SER_HOLD_BUF_EN
        // A word parked in hold as the previous one finished is started first.
        if (hold_full) begin
          shreg_nx     = hold;
          hold_full_nx = 1'b0;
          bit_cnt_nx   = '0;
          state_nx     = SHIFT;
        end else if (accept) begin
          shreg_nx   = din;
          bit_cnt_nx = '0;
          state_nx   = SHIFT;
        end
`else
        if (accept) begin
          shreg_nx   = din;
          bit_cnt_nx = '0;
          state_nx   = SHIFT;
        end
`endif
      end
      SHIFT: begin
        xout_nx       = shreg[WIDTH-1];
        xout_valid_nx = 1'b1;
        shreg_nx      = {shreg[WIDTH-2:0], 1'b0};
        bit_cnt_nx    = bit_cnt + 1'b1;
        if (bit_cnt == LAST_CNT) begin
          xout_last_nx = 1'b1;
          bit_cnt_nx   = '0;
          state_nx     = IDLE;
`ifdef SER_HOLD_BUF_EN
          if (hold_full) begin
            shreg_nx     = hold;
            hold_full_nx = 1'b0;
            state_nx     = SHIFT;
          end
`endif
        end
`ifdef SER_HOLD_BUF_EN
        // Evaluated after the drain so a same-edge refill keeps hold_full set.
        if (accept) begin
          hold_nx      = din;
          hold_full_nx = 1'b1;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      xout       <= IDLE_BIT;
      xout_valid <= 1'b0;
      xout_last  <= 1'b0;
`ifdef SER_HOLD_BUF_EN
      hold       <= '0;
      hold_full  <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      bit_cnt    <= bit_cnt_nx;
      xout       <= xout_nx;
      xout_valid <= xout_valid_nx;
      xout_last  <= xout_last_nx;
`ifdef SER_HOLD_BUF_EN
      hold       <= hold_nx;
      hold_full  <= hold_full_nx;
`endif
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: three instances (WIDTH 4, 8, and 2 with IDLE_BIT=1).
// Expectations adapt to SER_HOLD_BUF_EN when it is defined.
module tb_bit_serializer;

  logic clk = 1'b0;
  logic rst;

  logic [3:0] din4;
  logic       v4, rdy4, x4, xv4, xl4, busy4;
  logic [7:0] din8;
  logic       v8, rdy8, x8, xv8, xl8, busy8;
  logic [1:0] din2;
  logic       v2, rdy2, x2, xv2, xl2, busy2;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic ev [0:31];
  logic ex [0:31];
  logic el [0:31];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(4), .IDLE_BIT(1'b0)) dut4 (
    .clk(clk), .rst(rst), .din(din4), .din_valid(v4), .din_ready(rdy4),
    .xout(x4), .xout_valid(xv4), .xout_last(xl4), .busy(busy4));

  bit_serializer #(.WIDTH(8), .IDLE_BIT(1'b0)) dut8 (
    .clk(clk), .rst(rst), .din(din8), .din_valid(v8), .din_ready(rdy8),
    .xout(x8), .xout_valid(xv8), .xout_last(xl8), .busy(busy8));

  bit_serializer #(.WIDTH(2), .IDLE_BIT(1'b1)) dut2 (
    .clk(clk), .rst(rst), .din(din2), .din_valid(v2), .din_ready(rdy2),
    .xout(x2), .xout_valid(xv2), .xout_last(xl2), .busy(busy2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic [31:0] w, input logic v);
    case (sel)
      4: begin din4 = w[3:0]; v4 = v; end
      8: begin din8 = w[7:0]; v8 = v; end
      default: begin din2 = w[1:0]; v2 = v; end
    endcase
  endtask

  task automatic observe(input int sel, output logic x, output logic xv,
                         output logic xl, output logic rdy);
    case (sel)
      4: begin x = x4; xv = xv4; xl = xl4; rdy = rdy4; end
      8: begin x = x8; xv = xv8; xl = xl8; rdy = rdy8; end
      default: begin x = x2; xv = xv2; xl = xl2; rdy = rdy2; end
    endcase
  endtask

  // Expected-stream model: a word starting at edge 'start' shows its bits MSB-first.
  task automatic place_word(input int start, input int width, input logic [31:0] w);
    for (int i = 0; i < width; i++) begin
      ev[start+i] = 1'b1;
      ex[start+i] = w[width-1-i];
      el[start+i] = (i == width - 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(4, 0, 1'b0);
    drive(8, 0, 1'b0);
    drive(2, 0, 1'b0);
    tick();
    tick();
    check_cnt++;
    if ({x4, xv4, xl4, busy4, rdy4} !== 5'b00000)
      $display("[TB] FAIL reset_w4 got %b want 00000", {x4, xv4, xl4, busy4, rdy4});
    else pass_cnt++;
    check_cnt++;
    if ({x8, xv8, xl8, busy8, rdy8} !== 5'b00000)
      $display("[TB] FAIL reset_w8 got %b want 00000", {x8, xv8, xl8, busy8, rdy8});
    else pass_cnt++;
    check_cnt++;
    if ({x2, xv2, xl2, busy2, rdy2} !== 5'b10000)
      $display("[TB] FAIL reset_w2_idle1 got %b want 10000", {x2, xv2, xl2, busy2, rdy2});
    else pass_cnt++;
    rst = 1'b0;
    #1;
    check_cnt++;
    if ({rdy4, rdy8, rdy2} !== 3'b111)
      $display("[TB] FAIL ready_after_reset got %b want 111", {rdy4, rdy8, rdy2});
    else pass_cnt++;
  endtask

  task automatic test_single_word();
    logic [3:0] w;
    w = 4'b1011;
    drive(4, {28'd0, w}, 1'b1);
    tick();
    drive(4, 0, 1'b0);
    check_cnt++;
    if ({busy4, xv4} !== 2'b10)
      $display("[TB] FAIL single_accept busy/valid got %b want 10", {busy4, xv4});
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_cnt++;
      if ({x4, xv4, xl4} !== {w[3-i], 1'b1, (i == 3) ? 1'b1 : 1'b0})
        $display("[TB] FAIL single_bit%0d got %b want %b", i, {x4, xv4, xl4},
                 {w[3-i], 1'b1, (i == 3) ? 1'b1 : 1'b0});
      else pass_cnt++;
    end
    tick();
    check_cnt++;
    if ({x4, xv4, xl4, busy4} !== 4'b0000)
      $display("[TB] FAIL single_return_idle got %b want 0000", {x4, xv4, xl4, busy4});
    else pass_cnt++;
  endtask

  // Two words presented back to back with valid held; checks the whole output stream.
  task automatic run_stream(input int sel, input int width, input logic [31:0] w0,
                            input logic [31:0] w1, input int start1, input int ncyc,
                            input int rdy_from, input int rdy_to, input string name);
    int   widx;
    logic acc, x, xv, xl, rdy;
    for (int c = 0; c < 32; c++) begin
      ev[c] = 1'b0; ex[c] = 1'b0; el[c] = 1'b0;
    end
    place_word(2, width, w0);
    place_word(start1, width, w1);
    widx = 0;
    drive(sel, w0, 1'b1);
    for (int c = 1; c <= ncyc; c++) begin
      observe(sel, x, xv, xl, rdy);
      acc = rdy && (widx < 2);
      tick();
      if (acc) widx++;
      if (widx == 0) drive(sel, w0, 1'b1);
      else if (widx == 1) drive(sel, w1, 1'b1);
      else drive(sel, 0, 1'b0);
      observe(sel, x, xv, xl, rdy);
      check_cnt++;
      if ({x, xv, xl} !== {ex[c], ev[c], el[c]})
        $display("[TB] FAIL %s edge%0d x/v/last got %b want %b", name, c, {x, xv, xl},
                 {ex[c], ev[c], el[c]});
      else pass_cnt++;
      if (c >= rdy_from && c <= rdy_to) begin
        check_cnt++;
        if (rdy !== 1'b0)
          $display("[TB] FAIL %s edge%0d din_ready got %b want 0", name, c, rdy);
        else pass_cnt++;
      end
    end
    check_cnt++;
    if (widx != 2)
      $display("[TB] FAIL %s words_accepted got %0d want 2", name, widx);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
`ifdef SER_HOLD_BUF_EN
    run_stream(4, 4, 32'b1011, 32'b0110, 6, 12, 2, 4, "back_to_back");
`else
    run_stream(4, 4, 32'b1011, 32'b0110, 7, 12, 2, 4, "back_to_back");
`endif
  endtask

  task automatic test_backpressure();
`ifdef SER_HOLD_BUF_EN
    run_stream(8, 8, 32'h3C, 32'hA5, 10, 20, 2, 8, "backpressure");
`else
    run_stream(8, 8, 32'h3C, 32'hA5, 11, 20, 2, 8, "backpressure");
`endif
  endtask

  task automatic test_reset_mid_word();
    drive(8, 32'hFF, 1'b1);
    tick();
    drive(8, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_cnt++;
      if ({x8, xv8} !== 2'b11)
        $display("[TB] FAIL midreset_bit%0d got %b want 11", i, {x8, xv8});
      else pass_cnt++;
    end
    rst = 1'b1;
    #1;
    check_cnt++;
    if (rdy8 !== 1'b0)
      $display("[TB] FAIL midreset_ready_in_rst got %b want 0", rdy8);
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({x8, xv8, busy8} !== 3'b000)
      $display("[TB] FAIL midreset_after_edge got %b want 000", {x8, xv8, busy8});
    else pass_cnt++;
    rst = 1'b0;
    #1;
    check_cnt++;
    if (rdy8 !== 1'b1)
      $display("[TB] FAIL midreset_ready_after got %b want 1", rdy8);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_cnt++;
      if ({x8, xv8} !== 2'b00)
        $display("[TB] FAIL midreset_quiet%0d got %b want 00", i, {x8, xv8});
      else pass_cnt++;
    end
  endtask

  task automatic test_idle_high();
    check_cnt++;
    if ({x2, xv2} !== 2'b10)
      $display("[TB] FAIL idle1_level got %b want 10", {x2, xv2});
    else pass_cnt++;
    drive(2, 32'b00, 1'b1);
    tick();
    drive(2, 0, 1'b0);
    tick();
    check_cnt++;
    if ({x2, xv2, xl2} !== 3'b010)
      $display("[TB] FAIL idle1_bit0 got %b want 010", {x2, xv2, xl2});
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({x2, xv2, xl2} !== 3'b011)
      $display("[TB] FAIL idle1_bit1 got %b want 011", {x2, xv2, xl2});
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({x2, xv2, xl2, busy2} !== 4'b1000)
      $display("[TB] FAIL idle1_return got %b want 1000", {x2, xv2, xl2, busy2});
    else pass_cnt++;
  endtask

  task automatic test_reset_during_accept();
    rst = 1'b1;
    drive(4, 32'hF, 1'b1);
    #1;
    check_cnt++;
    if (rdy4 !== 1'b0)
      $display("[TB] FAIL rst_accept_ready got %b want 0", rdy4);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    drive(4, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_cnt++;
      if ({x4, xv4, busy4} !== 3'b000)
        $display("[TB] FAIL rst_accept_quiet%0d got %b want 000", i, {x4, xv4, busy4});
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    tick();
    test_back_to_back();
    tick();
    tick();
    test_backpressure();
    tick();
    tick();
    test_reset_mid_word();
    test_idle_high();
    test_reset_during_accept();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
